mem_fill_arbiter: RTL

- Sits between the I-cache/D-cache and the single multi-cycle main memory (memory4c: 16-bit words, pipelined, data_valid strobe).
- Arbitrates I-cache line fills, D-cache line fills and D-cache write-through stores onto the one memory port.
- Sequences the 8-word line reads and streams the returned words back to the requesting cache with word index and write enables.
- Owns the stall-release timing of both caches: ISTALL/DSTALL drop on the *_fill_done / d_wr_ack pulses.

---
 rtl/mem_fill_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mem_fill_arbiter.sv
// Memory-port arbiter for I/D line fills and D write-through stores; Moore outputs from registered state.
// Latency: fill issues 8 reads back to back, done pulse one cycle after last valid; store takes one cycle.
// Backpressure: requests are level-held and wait while busy; MEM_FILL_CWF_EN enables critical-word-first.
module mem_fill_arbiter #(
  parameter int WORDS_PER_LINE = 8,
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              i_miss,
  input  logic [ADDR_W-1:0]                 i_miss_addr,
  input  logic                              d_miss,
  input  logic [ADDR_W-1:0]                 d_miss_addr,
  input  logic                              d_wr_req,
  input  logic [ADDR_W-1:0]                 d_wr_addr,
  input  logic [DATA_W-1:0]                 d_wr_data,
  output logic [ADDR_W-1:0]                 mem_addr,
  output logic [DATA_W-1:0]                 mem_wdata,
  output logic                              mem_enable,
  output logic                              mem_wr,
  input  logic [DATA_W-1:0]                 mem_rdata,
  input  logic                              mem_data_valid,
  output logic [DATA_W-1:0]                 fill_data,
  output logic [$clog2(WORDS_PER_LINE)-1:0] fill_word,
  output logic                              i_fill_we,
  output logic                              d_fill_we,
  output logic                              i_fill_done,
  output logic                              d_fill_done,
  output logic                              d_wr_ack,
  output logic                              busy
);

  localparam int CW    = $clog2(WORDS_PER_LINE);
  localparam int CNT_W = CW + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(WORDS_PER_LINE);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(WORDS_PER_LINE - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(2 * WORDS_PER_LINE - 1);

  typedef enum logic [2:0] {IDLE, FILL_I, FILL_D, WRITE, DONE_I, DONE_D} state_t;

  state_t            state;
  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  recv_cnt;
  logic [ADDR_W-1:0] addr_q;   // line base during fills, full store address during WRITE
  logic [DATA_W-1:0] wdata_q;
  logic [CW-1:0]     issue_word;
  logic [CW-1:0]     recv_word;

`ifdef MEM_FILL_CWF_EN
  logic [CW-1:0] w0_q;
  assign issue_word = w0_q + issue_cnt[CW-1:0];
  assign recv_word  = w0_q + recv_cnt[CW-1:0];
`else
  assign issue_word = issue_cnt[CW-1:0];
  assign recv_word  = recv_cnt[CW-1:0];
`endif

  logic filling, issuing, rx;
  logic arb_ok, accept_i, accept_d, accept_w;

  assign filling = (state == FILL_I) || (state == FILL_D);
  assign issuing = filling && (issue_cnt < FULL_CNT);
  // Valids outside a fill, or past the end of the line, are dropped here.
  assign rx      = filling && mem_data_valid && (recv_cnt < FULL_CNT);

  // The request just served is still held during its DONE cycle, so it is masked there.
  assign arb_ok   = (state == IDLE) || (state == DONE_I) || (state == DONE_D);
  assign accept_i = arb_ok && i_miss && (state != DONE_I);
  assign accept_d = arb_ok && d_miss && (state != DONE_D) && !accept_i;
  assign accept_w = arb_ok && d_wr_req && !accept_i && !accept_d;

  // State, counters and latched request info.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
`ifdef MEM_FILL_CWF_EN
      w0_q      <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE_I, DONE_D: begin
          issue_cnt <= '0;
          recv_cnt  <= '0;
          if (accept_i) begin
            state  <= FILL_I;
            addr_q <= i_miss_addr & LINE_MASK;
`ifdef MEM_FILL_CWF_EN
            w0_q   <= i_miss_addr[CW:1];
`endif
          end else if (accept_d) begin
            state  <= FILL_D;
            addr_q <= d_miss_addr & LINE_MASK;
`ifdef MEM_FILL_CWF_EN
            w0_q   <= d_miss_addr[CW:1];
`endif
          end else if (accept_w) begin
            state   <= WRITE;
            addr_q  <= d_wr_addr;
            wdata_q <= d_wr_data;
          end else begin
            state <= IDLE;
          end
        end
        FILL_I, FILL_D: begin
          if (issuing) issue_cnt <= issue_cnt + 1'b1;
          if (rx) begin
            recv_cnt <= recv_cnt + 1'b1;
            if (recv_cnt == LAST_CNT) state <= (state == FILL_I) ? DONE_I : DONE_D;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output decode from registered state; only the fill data path passes mem_rdata straight through.
  always_comb begin
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_enable  = 1'b0;
    mem_wr      = 1'b0;
    fill_data   = '0;
    fill_word   = '0;
    i_fill_we   = 1'b0;
    d_fill_we   = 1'b0;
    i_fill_done = 1'b0;
    d_fill_done = 1'b0;
    d_wr_ack    = 1'b0;
    busy        = (state != IDLE);
    case (state)
      FILL_I, FILL_D: begin
        if (issuing) begin
          mem_enable = 1'b1;
          mem_addr   = {addr_q[ADDR_W-1:CW+1], issue_word, 1'b0};
        end
        if (rx) begin
          fill_data = mem_rdata;
          fill_word = recv_word;
          i_fill_we = (state == FILL_I);
          d_fill_we = (state == FILL_D);
        end
      end
      WRITE: begin
        mem_enable = 1'b1;
        mem_wr     = 1'b1;
        mem_addr   = addr_q;
        mem_wdata  = wdata_q;
        d_wr_ack   = 1'b1;
      end
      DONE_I:  i_fill_done = 1'b1;
      DONE_D:  d_fill_done = 1'b1;
      default: ;
    endcase
  end

endmodule
